byte_interleaver: RTL and testbench

- Block interleaver in the transmitter datapath, after the rate-1/2 FEC encoder.
- Takes the 96-bit FEC codeword as 12 bytes and emits a 96-bit word.
- The 12x8 bit matrix is written row-wise (one byte per row) and read column-wise, spreading burst errors.
- Also supports the inverse permutation (deinterleave) for loopback/receiver use.
- Registered output, 1-cycle latency.

---
 rtl/interleaver_pkg.sv | 23 ++
 rtl/il_permute.sv | 31 +++
 rtl/byte_interleaver.sv | 73 +++++++
 tb/tb_byte_interleaver.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/interleaver_pkg.sv
// rtl/interleaver_pkg.sv - shared geometry, word type and index helpers for the byte interleaver
// Purpose: 12x8 bit matrix constants, 96-bit word type, bit-position helpers.
// Ports: none (package).
package interleaver_pkg;

    localparam int ROWS   = 12;
    localparam int COLS   = 8;
    localparam int WORD_W = 96;

    typedef logic [WORD_W-1:0] word_t;

    // Bit position of row r, bit c in the row-major (byte-wise) word.
    function automatic int rm_index(input int r, input int c);
        return (WORD_W - 1) - COLS * r - ((COLS - 1) - c);
    endfunction

    // Bit position of row r, bit c in the column-major (interleaved) word.
    // Column 7 leads, rows 0..11 within each column.
    function automatic int il_index(input int r, input int c);
        return (WORD_W - 1) - (ROWS * ((COLS - 1) - c) + r);
    endfunction

endpackage

// File: rtl/il_permute.sv
// rtl/il_permute.sv - combinational forward/inverse row/column bit permutation
// Purpose: pure wiring permutation of a 96-bit word, mode-selected.
// Ports:
//   din_i   in  96  row-major word {b0..b11} (or interleaved word when deinterleaving)
//   mode_i  in  1   0 = interleave, 1 = deinterleave
//   dout_o  out 96  permuted word
module il_permute
    import interleaver_pkg::*;
(
    input  logic [WORD_W-1:0] din_i,
    input  logic              mode_i,
    output logic [WORD_W-1:0] dout_o
);

    word_t fwd;
    word_t inv;

    // Each matrix cell maps one row-major position to one column-major position;
    // the inverse simply swaps source and destination.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int IL = il_index(r, c);
            localparam int RM = rm_index(r, c);
            assign fwd[IL] = din_i[RM];
            assign inv[RM] = din_i[IL];
        end
    end

    assign dout_o = mode_i ? inv : fwd;

endmodule

// File: rtl/byte_interleaver.sv
// rtl/byte_interleaver.sv - 12-byte block interleaver/deinterleaver with registered output
// Purpose: permutes a 96-bit codeword (12 rows x 8 bits) written row-wise,
//          read column-wise; mode selects the inverse. 1-cycle latency.
// Ports:
//   clk        in  1   clock, rising edge
//   reset      in  1   synchronous, active-high
//   in_valid   in  1   capture b0..b11 on this edge
//   mode       in  1   0 = interleave, 1 = deinterleave
//   b0..b11    in  8   rows 0..11, b0 is the MSB byte
//   final_ans  out 96  permuted word, registered
//   out_valid  out 1   final_ans updated this cycle
module byte_interleaver
    import interleaver_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        mode,
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    input  logic [7:0]  b2,
    input  logic [7:0]  b3,
    input  logic [7:0]  b4,
    input  logic [7:0]  b5,
    input  logic [7:0]  b6,
    input  logic [7:0]  b7,
    input  logic [7:0]  b8,
    input  logic [7:0]  b9,
    input  logic [7:0]  b10,
    input  logic [7:0]  b11,
    output logic [95:0] final_ans,
    output logic        out_valid
);

    word_t in_word;
    word_t perm;
    word_t ans_d;
    word_t ans_q;
    logic  valid_d;
    logic  valid_q;

    assign in_word = {b0, b1, b2, b3, b4, b5, b6, b7, b8, b9, b10, b11};

    il_permute u_permute (
        .din_i  (in_word),
        .mode_i (mode),
        .dout_o (perm)
    );

    // Output holds its last value between accepted words.
    always_comb begin
        ans_d   = ans_q;
        valid_d = 1'b0;
        if (in_valid) begin
            ans_d   = perm;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ans_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ans_q   <= ans_d;
            valid_q <= valid_d;
        end
    end

    assign final_ans = ans_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_byte_interleaver.sv
// tb/tb_byte_interleaver.sv - self-checking bench for byte_interleaver
module tb_byte_interleaver;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        mode;
    logic [7:0]  b [12];
    logic [95:0] final_ans;
    logic        out_valid;

    int n_assert = 0;
    int n_fail   = 0;

    logic [95:0] exp_q [$];
    logic [95:0] held;
    logic [95:0] rt_mid;

    always #5 clk = ~clk;

    byte_interleaver dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .mode      (mode),
        .b0        (b[0]),
        .b1        (b[1]),
        .b2        (b[2]),
        .b3        (b[3]),
        .b4        (b[4]),
        .b5        (b[5]),
        .b6        (b[6]),
        .b7        (b[7]),
        .b8        (b[8]),
        .b9        (b[9]),
        .b10       (b[10]),
        .b11       (b[11]),
        .final_ans (final_ans),
        .out_valid (out_valid)
    );

    // Reference: interleaved output is the bit stream read column 7 first,
    // rows 0..11 within each column, packed MSB first.
    function automatic logic [95:0] model_il(input logic [95:0] w);
        logic [95:0] o;
        int j;
        o = '0;
        j = 95;
        for (int c = 7; c >= 0; c--) begin
            for (int r = 0; r < 12; r++) begin
                o[j] = w[95 - 8*r - (7 - c)];
                j--;
            end
        end
        return o;
    endfunction

    function automatic logic [95:0] model_dil(input logic [95:0] w);
        logic [95:0] o;
        int j;
        o = '0;
        j = 95;
        for (int c = 7; c >= 0; c--) begin
            for (int r = 0; r < 12; r++) begin
                o[95 - 8*r - (7 - c)] = w[j];
                j--;
            end
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // One clock: drive inputs, update scoreboard, sample #1 after the edge.
    task automatic cycle(input string tag, input logic v, input logic m,
                         input logic [95:0] w, input logic rst);
        logic exp_v;
        for (int i = 0; i < 12; i++) b[i] = w[95 - 8*i -: 8];
        in_valid = v;
        mode     = m;
        reset    = rst;
        exp_v    = v && !rst;
        if (rst) begin
            exp_q.delete();
            held = '0;
        end else if (v) begin
            exp_q.push_back(m ? model_dil(w) : model_il(w));
        end
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, {95'b0, out_valid}, {95'b0, exp_v});
        if (exp_v && exp_q.size() > 0) held = exp_q.pop_front();
        chk({tag, ".data"}, final_ans, held);
        in_valid = 1'b0;
        reset    = 1'b0;
    endtask

    initial begin
        held     = '0;
        reset    = 1'b0;
        in_valid = 1'b0;
        mode     = 1'b0;
        for (int i = 0; i < 12; i++) b[i] = 8'h00;
        @(negedge clk);

        // Reset dominates in_valid with all-ones input.
        cycle("reset", 1'b1, 1'b0, {96{1'b1}}, 1'b1);
        chk("reset_const", final_ans, 96'h0);

        // Single-bit corners.
        cycle("b0_msb", 1'b1, 1'b0, 96'h800000000000000000000000, 1'b0);
        chk("b0_msb_const", final_ans, 96'h800000000000000000000000);
        cycle("b11_lsb", 1'b1, 1'b0, 96'h000000000000000000000001, 1'b0);
        chk("b11_lsb_const", final_ans, 96'h000000000000000000000001);

        // Row pattern and all-ones.
        cycle("row0", 1'b1, 1'b0, 96'hFF0000000000000000000000, 1'b0);
        chk("row0_const", final_ans, 96'h800800800800800800800800);
        cycle("ones", 1'b1, 1'b0, {96{1'b1}}, 1'b0);
        chk("ones_const", final_ans, {96{1'b1}});

        // Round trip interleave then deinterleave.
        cycle("rt_fwd", 1'b1, 1'b0, 96'h0123456789ABCDEF01234567, 1'b0);
        rt_mid = final_ans;
        cycle("rt_inv", 1'b1, 1'b1, rt_mid, 1'b0);
        chk("rt_const", final_ans, 96'h0123456789ABCDEF01234567);

        // Three back-to-back words, mode switching without a flush.
        cycle("s0", 1'b1, 1'b0, 96'hDEADBEEF0011223344556677, 1'b0);
        cycle("s1", 1'b1, 1'b1, 96'hA5A5A5A55A5A5A5AF0F0F0F0, 1'b0);
        cycle("s2", 1'b1, 1'b0, 96'h13579BDF02468ACE0F1E2D3C, 1'b0);

        // Idle: hold last value, changing inputs must not leak through.
        for (int k = 0; k < 5; k++) begin
            cycle("hold", 1'b0, k[0], {$urandom, $urandom, $urandom}, 1'b0);
        end

        // Reset mid-burst drops that word; next word processes normally.
        cycle("burst0", 1'b1, 1'b0, 96'hCAFEF00D1234567890ABCDEF, 1'b0);
        cycle("burst_rst", 1'b1, 1'b0, 96'hFFFFFFFF00000000FFFFFFFF, 1'b1);
        chk("burst_rst_const", final_ans, 96'h0);
        cycle("burst1", 1'b1, 1'b1, 96'h0F0F0F0F0F0F0F0F0F0F0F0F, 1'b0);
        cycle("idle_after", 1'b0, 1'b0, 96'h0, 1'b0);

        // Random words in both modes.
        for (int k = 0; k < 16; k++) begin
            cycle("rand", 1'b1, k[0], {$urandom, $urandom, $urandom}, 1'b0);
        end

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d expected %0d", exp_q.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
